// File: rtl/fetch_decode_fsm_pkg.sv
// Shared definitions for the instruction fetch/decode controller: opcodes, FSM states
// and instruction-register field positions.
package fetch_decode_fsm_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned P1_MSB  = 11;
  localparam int unsigned P1_LSB  = 6;
  localparam int unsigned P2_MSB  = 5;
  localparam int unsigned P2_LSB  = 0;

  typedef enum logic [3:0] {
    OpNop    = 4'h0,
    OpAluReg = 4'h1,
    OpAluImm = 4'h2,
    OpMov    = 4'h3,
    OpJmp    = 4'h4,
    OpHalt   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StNext   = 3'd4,
    StHalt   = 3'd5
  } state_e;

  // Opcodes that hand off to an external execute unit.
  function automatic logic is_exec_op(input logic [3:0] op);
    return (op == OpAluReg) || (op == OpAluImm) || (op == OpMov);
  endfunction

endpackage

// File: rtl/exec_timeout_counter.sv
// Cycle counter bounding how long EXEC waits for a unit's done; tc_o flags the last
// allowed cycle.
module exec_timeout_counter
  import fetch_decode_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_decode_fsm.sv
// Instruction fetch/decode controller: fetches over a ready handshake, dispatches to the
// execute units, and runs NOP/JMP/HALT itself.
module fetch_decode_fsm
  import fetch_decode_fsm_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned IW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [IW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            donefetch,
  output logic            start_alu_inm,
  output logic            start_alu_reg,
  output logic            start_mov,
  input  logic            done_alu_inm,
  input  logic            done_alu_reg,
  input  logic            done_mov,
  output logic [3:0]      opcode,
  output logic [5:0]      parameter1,
  output logic [5:0]      parameter2,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            err_q, err_d;
  logic            done_sel;
  logic            tc;
  logic [11:0]     jmp_tgt;

  assign opcode     = ir_q[OPC_MSB:OPC_LSB];
  assign parameter1 = ir_q[P1_MSB:P1_LSB];
  assign parameter2 = ir_q[P2_MSB:P2_LSB];
  assign jmp_tgt    = ir_q[P1_MSB:P2_LSB];
  assign pc         = pc_q;
  assign mem_addr   = pc_q;
  assign err        = err_q;

  // Only the selected unit's done counts; the others are ignored.
  always_comb begin
    done_sel = 1'b0;
    case (opcode)
      OpAluReg: done_sel = done_alu_reg;
      OpAluImm: done_sel = done_alu_inm;
      OpMov:    done_sel = done_mov;
      default:  done_sel = 1'b0;
    endcase
  end

  exec_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i((state_q != StExec) || done_sel),
    .en_i ((state_q == StExec) && !done_sel && !tc),
    .tc_o (tc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    err_d         = err_q;
    mem_rd        = 1'b0;
    donefetch     = 1'b0;
    start_alu_inm = 1'b0;
    start_alu_reg = 1'b0;
    start_mov     = 1'b0;
    halted        = 1'b0;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        donefetch = 1'b1;
        if (is_exec_op(opcode)) begin
          state_d = StExec;
        end else if (opcode == OpJmp) begin
          pc_d    = jmp_tgt[PC_W-1:0];
          state_d = StFetch;
        end else if (opcode == OpHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StNext;
        end
      end
      StExec: begin
        start_alu_reg = (opcode == OpAluReg);
        start_alu_inm = (opcode == OpAluImm);
        start_mov     = (opcode == OpMov);
        if (done_sel) begin
          state_d = StNext;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end
      StNext: begin
        pc_d    = pc_q + 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_fsm.sv
// Bench for fetch_decode_fsm: directed scenarios plus a random instruction stream checked
// against an instruction-level model of PC flow and unit dispatch.
module tb_fetch_decode_fsm;

  logic       clk = 1'b0;
  logic       rst, run;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [15:0] mem_rdata;
  logic       mem_ready;
  logic       donefetch, start_alu_inm, start_alu_reg, start_mov;
  logic       done_alu_inm, done_alu_reg, done_mov;
  logic [3:0] opcode;
  logic [5:0] parameter1, parameter2;
  logic [7:0] pc;
  logic       halted, err;

  int vecs = 0;
  int miss = 0;

  logic [7:0]  m_pc;
  logic [15:0] m_ir;

  fetch_decode_fsm #(
    .PC_W(8), .IW(16), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .donefetch(donefetch),
    .start_alu_inm(start_alu_inm), .start_alu_reg(start_alu_reg), .start_mov(start_mov),
    .done_alu_inm(done_alu_inm), .done_alu_reg(done_alu_reg), .done_mov(done_mov),
    .opcode(opcode), .parameter1(parameter1), .parameter2(parameter2),
    .pc(pc), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start line each opcode should raise, as {mov, alu_reg, alu_inm}.
  function automatic logic [2:0] unit_of(input logic [3:0] op);
    case (op)
      4'h1:    return 3'b010;
      4'h2:    return 3'b001;
      4'h3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] starts();
    return {start_mov, start_alu_reg, start_alu_inm};
  endfunction

  // Expects the DUT in FETCH at m_pc; serves word w and completes the instruction.
  task automatic run_insn(input logic [15:0] w, input int mem_lat, input int done_lat);
    logic [2:0] u;
    u = unit_of(w[15:12]);
    chk("fetch_rd", mem_rd, 1);
    chk("fetch_addr", mem_addr, m_pc);
    for (int i = 0; i < mem_lat; i++) begin
      mem_ready = 1'b0;
      step();
      chk("stall_rd", mem_rd, 1);
      chk("stall_ir", {opcode, parameter1, parameter2}, m_ir);
    end
    mem_ready = 1'b1;
    mem_rdata = w;
    step();
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
    m_ir = w;
    chk("dec_pulse", donefetch, 1);
    chk("dec_ir", {opcode, parameter1, parameter2}, w);
    chk("dec_start", starts(), 0);
    if (u != 3'b000) begin
      step();
      for (int i = 0; i < done_lat; i++) begin
        chk("exec_start", starts(), u);
        chk("exec_df", donefetch, 0);
        {done_mov, done_alu_reg, done_alu_inm} = 3'($urandom) & ~u;
        step();
      end
      chk("exec_start", starts(), u);
      chk("exec_ir", {opcode, parameter1, parameter2}, w);
      {done_mov, done_alu_reg, done_alu_inm} = u | (3'($urandom) & ~u);
      step();
      {done_mov, done_alu_reg, done_alu_inm} = 3'b000;
      chk("next_start", starts(), 0);
      chk("next_pc", pc, m_pc);
      step();
      m_pc = m_pc + 8'd1;
    end else if (w[15:12] == 4'hF) begin
      step();
      chk("halt_flag", halted, 1);
      chk("halt_rd", mem_rd, 0);
    end else if (w[15:12] == 4'h4) begin
      step();
      chk("jmp_start", starts(), 0);
      m_pc = w[7:0];
    end else begin
      step();
      chk("nop_rd", mem_rd, 0);
      chk("nop_start", starts(), 0);
      step();
      m_pc = m_pc + 8'd1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    done_alu_inm = 1'b0; done_alu_reg = 1'b0; done_mov = 1'b0;
    m_pc = '0; m_ir = '0;
    step();
    chk("rst_pc", pc, 0);
    chk("rst_outs", {mem_rd, donefetch, starts(), halted, err}, 0);
    chk("rst_ir", {opcode, parameter1, parameter2}, 0);

    // First ALU-immediate, then NOP and JMP.
    rst = 1'b1;
    step();
    chk("idle_rd", mem_rd, 0);
    run = 1'b1;
    step();
    run_insn(16'h20C5, 1, 4);
    chk("t1_pc", pc, 1);
    chk("t1_addr", mem_addr, 1);
    run_insn(16'h0000, 0, 0);
    run_insn(16'h400A, 0, 0);
    chk("jmp_addr", mem_addr, 8'h0A);

    // Random instruction stream; run toggling must not matter.
    for (int k = 0; k < 40; k++) begin
      run = 1'($urandom);
      run_insn({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 3),
               $urandom_range(0, 6));
    end
    chk("rand_pc", pc, m_pc);

    // PC wrap and long fetch stall.
    run_insn(16'h40FF, 0, 0);
    chk("pre_wrap", pc, 8'hFF);
    run_insn(16'h0000, 2, 0);
    chk("wrap", pc, 8'h00);
    run_insn(16'h2ABC, 10, 2);

    // HALT at pc=5 is sticky against run.
    run_insn(16'h4005, 0, 0);
    run_insn(16'hF000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      step();
    end
    chk("halt_stay", halted, 1);
    chk("halt_pc", pc, 5);
    rst = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_outs", {mem_rd, donefetch, starts(), halted, err}, 0);

    // EXEC timeout on MOV.
    rst = 1'b1; run = 1'b1; m_pc = '0; m_ir = '0;
    step();
    mem_ready = 1'b1; mem_rdata = 16'h3041;
    step();
    mem_ready = 1'b0;
    chk("to_dec", donefetch, 1);
    step();
    n = 0;
    while (start_mov === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("to_cycles", n, 64);
    chk("to_err", err, 1);
    chk("to_halt", halted, 1);
    chk("to_start", start_mov, 0);
    done_mov = 1'b1;
    step();
    step();
    done_mov = 1'b0;
    chk("to_sticky", {halted, err, starts()}, 5'b11000);

    // Reset in the middle of an ALU-register EXEC.
    rst = 1'b0;
    #1;
    chk("rst2_err", err, 0);
    rst = 1'b1;
    step();
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ready = 1'b0;
    step();
    chk("mid_start", start_alu_reg, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_drop", {start_alu_reg, mem_rd, donefetch, err, halted}, 0);
    run = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_idle", mem_rd, 0);
    step();
    chk("mid_idle2", {mem_rd, pc}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
